// File: rtl/reg_file_sb_if.sv
// Purpose : port bundle between decode/writeback and the register file scoreboard.
// Latency : n/a (wiring only); reads combinational, writes and reservations land at the next CLK edge.
// Backpres: RSV_STALL refuses a reservation; the requester holds RSV_EN/RSV_REG and retries.
// Ports   : RD_REG/RD_DATA/RD_BUSY (read side), WR0_* (ALU writeback), WR1_* (load writeback),
//           RSV_EN/RSV_REG/RSV_STALL (load reservation). master = pipeline side, slave = register file.
interface reg_file_sb_if #(
    parameter int DW       = 64,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD*AW-1:0] RD_REG;
    logic [NUM_RD*DW-1:0] RD_DATA;
    logic [NUM_RD-1:0]    RD_BUSY;

    logic                 WR0_EN;
    logic [AW-1:0]        WR0_REG;
    logic [DW-1:0]        WR0_DATA;

    logic                 WR1_EN;
    logic [AW-1:0]        WR1_REG;
    logic [DW-1:0]        WR1_DATA;

    logic                 RSV_EN;
    logic [AW-1:0]        RSV_REG;
    logic                 RSV_STALL;

    modport master (
        output RD_REG, WR0_EN, WR0_REG, WR0_DATA, WR1_EN, WR1_REG, WR1_DATA, RSV_EN, RSV_REG,
        input  RD_DATA, RD_BUSY, RSV_STALL
    );

    modport slave (
        input  RD_REG, WR0_EN, WR0_REG, WR0_DATA, WR1_EN, WR1_REG, WR1_DATA, RSV_EN, RSV_REG,
        output RD_DATA, RD_BUSY, RSV_STALL
    );
endinterface

// File: rtl/reg_file_sb.sv
// Purpose : LEGv8 integer register file, two write ports, XZR, optional write bypass, load busy scoreboard.
// Latency : reads combinational; writes/busy updates visible one cycle after the CLK edge (0 with BYPASS).
// Backpres: RSV_STALL refuses a reservation of a still-busy register; requester holds and retries.
// Ports   : CLK, RST_N (synchronous, active-low), bus (reg_file_sb_if.slave): read ports,
//           WR0 (ALU writeback), WR1 (load writeback, clears busy), reservation request/stall.
module reg_file_sb #(
    parameter int DW       = 64,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    reg_file_sb_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DW-1:0]       regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_nxt;

    logic                wr0_ok;
    logic                wr1_ok;
    logic                rsv_ok;
    logic                busy_rsv;
    logic                rsv_stall;

    logic [NUM_RD*DW-1:0] rd_data_v;
    logic [NUM_RD-1:0]    rd_busy_v;

    // A register is "real" when it exists (non power-of-2 depths leave holes) and is not XZR.
    function automatic logic in_use(input logic [AW-1:0] a);
        return (int'(a) < NUM_REGS) && (int'(a) != ZERO_REG);
    endfunction

    assign wr0_ok = bus.WR0_EN && in_use(bus.WR0_REG);
    assign wr1_ok = bus.WR1_EN && in_use(bus.WR1_REG);

    always_comb begin
        busy_rsv = 1'b0;
        if (in_use(bus.RSV_REG)) begin
            busy_rsv = busy[bus.RSV_REG];
        end
    end

    // A load writeback to the same register this cycle frees it in time for the new reservation.
    assign rsv_stall = bus.RSV_EN && busy_rsv && !(bus.WR1_EN && (bus.WR1_REG == bus.RSV_REG));
    assign rsv_ok    = bus.RSV_EN && in_use(bus.RSV_REG) && !rsv_stall;

    // Set is evaluated after clear so a new load issued in the cycle the old one returns stays busy.
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wr1_ok && (int'(bus.WR1_REG) == r)) begin
                busy_nxt[r] = 1'b0;
            end
            if (rsv_ok && (int'(bus.RSV_REG) == r)) begin
                busy_nxt[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            // WR0 is issued last so it overrides WR1 on a same-register collision (ALU op is younger).
            if (wr1_ok) begin
                regs[bus.WR1_REG] <= bus.WR1_DATA;
            end
            if (wr0_ok) begin
                regs[bus.WR0_REG] <= bus.WR0_DATA;
            end
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rd_data_v = '0;
        rd_busy_v = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            logic [AW-1:0] a;
            a = bus.RD_REG[i*AW +: AW];
            if (in_use(a)) begin
                if ((BYPASS != 0) && wr0_ok && (bus.WR0_REG == a)) begin
                    rd_data_v[i*DW +: DW] = bus.WR0_DATA;
                end else if ((BYPASS != 0) && wr1_ok && (bus.WR1_REG == a)) begin
                    rd_data_v[i*DW +: DW] = bus.WR1_DATA;
                end else begin
                    rd_data_v[i*DW +: DW] = regs[a];
                end
                rd_busy_v[i] = busy[a] && !((BYPASS != 0) && wr1_ok && (bus.WR1_REG == a));
            end
        end
    end

    assign bus.RD_DATA   = rd_data_v;
    assign bus.RD_BUSY   = rd_busy_v;
    assign bus.RSV_STALL = rsv_stall;
endmodule
